// File: rtl/conv_udiv_32u_16u_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
// master: ap_start, dividend, divisor out; slave: ap_ready/idle/done, results out.
interface conv_udiv_32u_16u_seq_if #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
);
  logic                      ap_start;
  logic                      ap_ready;
  logic                      ap_idle;
  logic                      ap_done;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;

  modport master (
    output ap_start, dividend, divisor,
    input  ap_ready, ap_idle, ap_done,
    input  quotient, remainder, div_by_zero
  );

  modport slave (
    input  ap_start, dividend, divisor,
    output ap_ready, ap_idle, ap_done,
    output quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/conv_udiv_32u_16u_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// Ports: ap_clk, ap_rst (async, active-high), bus (slave handshake + data).
module conv_udiv_32u_16u_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input logic ap_clk,
  input logic ap_rst,
  conv_udiv_32u_16u_seq_if.slave bus
);
  localparam int CW = $clog2(DIVIDEND_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic                      ready, idle, done;
  logic [CW-1:0]             cnt;
  // Dividend bits shift out of the MSB while quotient bits enter the LSB.
  logic [DIVIDEND_WIDTH-1:0] acc, acc_nx;
  logic [DIVISOR_WIDTH-1:0]  dvs;
  logic [DIVISOR_WIDTH-1:0]  rem, rem_nx, dif;
  logic [DIVISOR_WIDTH:0]    shf;
  logic                      ge, last;
  logic [DIVIDEND_WIDTH-1:0] quo_q;
  logic [DIVISOR_WIDTH-1:0]  rem_q;
  logic                      dbz_q;

  always_comb begin
    shf    = {rem, acc[DIVIDEND_WIDTH-1]};
    ge     = shf >= {1'b0, dvs};
    // When ge holds the true difference is < dvs, so DW bits suffice.
    dif    = shf[DIVISOR_WIDTH-1:0] - dvs;
    rem_nx = ge ? dif : shf[DIVISOR_WIDTH-1:0];
    acc_nx = {acc[DIVIDEND_WIDTH-2:0], ge};
    last   = cnt == CW'(DIVIDEND_WIDTH - 1);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    idle     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (bus.ap_start) begin
          ready    = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: if (last) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt   <= '0;
      acc   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else if (ready) begin
      acc <= bus.dividend;
      dvs <= bus.divisor;
      rem <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= acc_nx;
      rem <= rem_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        quo_q <= acc_nx;
        rem_q <= rem_nx;
        dbz_q <= dvs == '0;
      end
    end
  end

  assign bus.ap_ready    = ready;
  assign bus.ap_idle     = idle;
  assign bus.ap_done     = done;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_conv_udiv_32u_16u_seq.sv
// Self-checking bench for the sequential unsigned divider.
// Scoreboard queue of expected results, per-scenario tasks.
module tb_conv_udiv_32u_16u_seq;
  localparam int AW = 32;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_udiv_32u_16u_seq_if #(
    .DIVIDEND_WIDTH(AW),
    .DIVISOR_WIDTH(BW)
  ) bus ();

  conv_udiv_32u_16u_seq #(
    .DIVIDEND_WIDTH(AW),
    .DIVISOR_WIDTH(BW)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          z;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [AW-1:0] a,
                                 input logic [BW-1:0] b);
    exp_t e;
    logic [AW-1:0] m;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q = '1;
      e.r = a[BW-1:0];
      e.z = 1'b1;
    end else begin
      e.q = a / {16'd0, b};
      m   = a % {16'd0, b};
      e.r = m[BW-1:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Drives one request at a negedge; returns at the negedge of cycle 1.
  task automatic start_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                          output bit rdy);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.ap_start = 1'b1;
    #1;
    rdy = bus.ap_ready;
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.ap_start = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
  endtask

  // Cycle index (accept = 0) of ap_done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (lat < 60) begin
      #1;
      if (bus.ap_done === 1'b1) return;
      @(negedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.ap_start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.ap_ready !== 1'b0 || bus.ap_done !== 1'b0 ||
        bus.ap_idle !== 1'b1 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b done=%b idle=%b q=%h r=%h z=%b required 0 0 1 0 0 0",
               bus.ap_ready, bus.ap_done, bus.ap_idle, bus.quotient,
               bus.remainder, bus.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit rdy;
    int lat;
    exp_t e;
    start_op(32'd100000, 16'd7, rdy);
    wait_done(lat);
    tests++;
    if (rdy !== 1'b1) begin
      fails++;
      $display("FAIL basic_ready: got %b required 1", rdy);
    end
    tests++;
    if (lat != 33) begin
      fails++;
      $display("FAIL basic_latency: got %0d required 33", lat);
    end
    e = sb.pop_front();
    tests++;
    if (bus.quotient !== 32'd14285 || bus.remainder !== 16'd5 ||
        bus.div_by_zero !== 1'b0 || e.q !== 32'd14285) begin
      fails++;
      $display("FAIL basic_result: q=%0d r=%0d z=%b required 14285 5 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_corners;
    logic [AW-1:0] ta [3];
    logic [BW-1:0] tb [3];
    bit rdy;
    int lat;
    exp_t e;
    ta = '{32'hFFFF_FFFF, 32'd0, 32'h0001_0000};
    tb = '{16'hFFFF, 16'h1234, 16'd1};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], rdy);
      wait_done(lat);
      e = sb.pop_front();
      tests++;
      if (lat != 33 || bus.quotient !== e.q || bus.remainder !== e.r ||
          bus.div_by_zero !== e.z) begin
        fails++;
        $display("FAIL corner_%0d: lat=%0d q=%h r=%h z=%b required 33 %h %h %b",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero,
                 e.q, e.r, e.z);
      end
    end
  endtask

  task automatic test_div_zero;
    bit rdy;
    int lat;
    start_op(32'd1234, 16'd0, rdy);
    wait_done(lat);
    void'(sb.pop_front());
    tests++;
    if (lat != 33 || bus.quotient !== 32'hFFFF_FFFF ||
        bus.remainder !== 16'h04D2 || bus.div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL div_zero: lat=%0d q=%h r=%h z=%b required 33 ffffffff 04d2 1",
               lat, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 16'h04D2 ||
        bus.div_by_zero !== 1'b1 || bus.ap_done !== 1'b0) begin
      fails++;
      $display("FAIL div_zero_hold: q=%h r=%h z=%b done=%b required ffffffff 04d2 1 0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.ap_done);
    end
  endtask

  task automatic test_back_to_back;
    int   nacc;
    bit   x_rdy, x_done, x_idle;
    exp_t e;
    nacc = 0;
    @(negedge clk);
    bus.dividend = 32'd987654;
    bus.divisor  = 16'd321;
    bus.ap_start = 1'b1;
    for (int c = 0; c <= 110; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10 || c == 45 || c == 80) begin
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom_range(1, 65535));
      end
      if (nacc == 3) bus.ap_start = 1'b0;
      #1;
      x_rdy  = (c == 0 || c == 34 || c == 68);
      x_done = (c == 33 || c == 67 || c == 101);
      x_idle = x_rdy || c >= 102;
      tests++;
      if (bus.ap_ready !== x_rdy || bus.ap_done !== x_done ||
          bus.ap_idle !== x_idle) begin
        fails++;
        $display("FAIL b2b_hs c%0d: rdy=%b done=%b idle=%b required %b %b %b",
                 c, bus.ap_ready, bus.ap_done, bus.ap_idle,
                 x_rdy, x_done, x_idle);
      end
      if (bus.ap_ready === 1'b1) begin
        sb.push_back(model(bus.dividend, bus.divisor));
        nacc++;
      end
      if (bus.ap_done === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL b2b_result c%0d: done with empty scoreboard", c);
        end else begin
          e = sb.pop_front();
          if (bus.quotient !== e.q || bus.remainder !== e.r ||
              bus.div_by_zero !== e.z) begin
            fails++;
            $display("FAIL b2b_result c%0d: q=%h r=%h z=%b required %h %h %b",
                     c, bus.quotient, bus.remainder, bus.div_by_zero,
                     e.q, e.r, e.z);
          end
        end
      end
    end
    bus.ap_start = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit rdy;
    int lat;
    int ndone;
    exp_t e;
    start_op(32'hDEAD_BEEF, 16'h1234, rdy);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.quotient !== '0 || bus.remainder !== '0 ||
        bus.div_by_zero !== 1'b0 || bus.ap_done !== 1'b0 ||
        bus.ap_ready !== 1'b0 || bus.ap_idle !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_async: q=%h r=%h z=%b done=%b rdy=%b idle=%b required 0 0 0 0 0 1",
               bus.quotient, bus.remainder, bus.div_by_zero,
               bus.ap_done, bus.ap_ready, bus.ap_idle);
    end
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ap_done === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %0d pulses required 0", ndone);
    end
    start_op(32'd5000001, 16'd13, rdy);
    wait_done(lat);
    e = sb.pop_front();
    tests++;
    if (lat != 33 || bus.quotient !== e.q || bus.remainder !== e.r ||
        bus.div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: lat=%0d q=%h r=%h required 33 %h %h",
               lat, bus.quotient, bus.remainder, e.q, e.r);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    longint unsigned lhs;
    bit rdy;
    int lat;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = 16'($urandom);
      unique case (i % 5)
        0: ;
        1: b = 16'd1;
        2: begin
          b = 16'($urandom_range(2, 65535));
          a = $urandom_range(0, 32'(b) - 1);
        end
        3: b = 16'hFFFF;
        default: if (i == 4) a = 32'hFFFF_FFFF;
      endcase
      start_op(a, b, rdy);
      wait_done(lat);
      e = sb.pop_front();
      tests++;
      if (lat != 33 || rdy !== 1'b1 || bus.quotient !== e.q ||
          bus.remainder !== e.r || bus.div_by_zero !== e.z) begin
        fails++;
        $display("FAIL rand_%0d %h/%h: lat=%0d q=%h r=%h z=%b required 33 %h %h %b",
                 i, a, b, lat, bus.quotient, bus.remainder,
                 bus.div_by_zero, e.q, e.r, e.z);
      end
      if (b != '0) begin
        lhs = longint'(bus.quotient) * longint'(b) + longint'(bus.remainder);
        tests++;
        if (lhs != longint'(a) || bus.remainder >= b) begin
          fails++;
          $display("FAIL rand_inv_%0d %h/%h: q*d+r=%h r=%h required %h r<d",
                   i, a, b, lhs, bus.remainder, a);
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
